rect_fill_engine: RTL

//  Rectangle rasteriser between the piano UI controller and vga_adapter. Takes one

---
 rtl/vga_draw_pkg.sv | 22 ++
 rtl/rect_fill_engine_if.sv | 39 +++
 rtl/raster_counter.sv | 79 +++++++
 rtl/rect_fill_engine.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/vga_draw_pkg.sv
// Shared VGA drawing definitions: FSM state encodings, default screen size and
// coordinate/colour widths, used by rect_fill_engine and vgadisplay.
package vga_draw_pkg;

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned CW = 3;

    localparam int unsigned XRES_DEFAULT = 160;
    localparam int unsigned YRES_DEFAULT = 120;

    typedef logic [XW-1:0] xcoord_t;
    typedef logic [YW-1:0] ycoord_t;
    typedef logic [CW-1:0] colour_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAW   = 2'd1,
        ST_FINISH = 2'd2
    } draw_state_e;

endpackage

// File: rtl/rect_fill_engine_if.sv
// Command and pixel-write bus of rect_fill_engine.
// Defining OUTLINE_EN adds the iOutline command bit (border-only drawing).
interface rect_fill_engine_if;
    import vga_draw_pkg::*;

    logic    iStart;
    xcoord_t iX0;
    ycoord_t iY0;
    xcoord_t iW;
    ycoord_t iH;
    colour_t iColour;
`ifdef OUTLINE_EN
    logic    iOutline;
`endif

    xcoord_t oX;
    ycoord_t oY;
    colour_t oColour;
    logic    oPlot;
    logic    oBusy;
    logic    oDone;

    modport master (
`ifdef OUTLINE_EN
        output iOutline,
`endif
        output iStart, iX0, iY0, iW, iH, iColour,
        input  oX, oY, oColour, oPlot, oBusy, oDone
    );

    modport slave (
`ifdef OUTLINE_EN
        input  iOutline,
`endif
        input  iStart, iX0, iY0, iW, iH, iColour,
        output oX, oY, oColour, oPlot, oBusy, oDone
    );

endinterface

// File: rtl/raster_counter.sv
// Nested x/y scan counter: x runs fastest, returns to x0 and steps y at row end.
// Publishes the next scan position so the owner can register it in the same cycle.
module raster_counter
    import vga_draw_pkg::*;
(
    input  logic    iClock,
    input  logic    iReset,
    input  logic    load_i,
    input  logic    en_i,
    input  xcoord_t x0_i,
    input  ycoord_t y0_i,
    input  xcoord_t x_last_i,
    input  ycoord_t y_last_i,
`ifdef OUTLINE_EN
    output logic    next_edge_o,
`endif
    output logic    last_o,
    output xcoord_t next_x_o,
    output ycoord_t next_y_o
);

    xcoord_t x_q, x_d, x0_q, xl_q;
    ycoord_t y_q, y_d, yl_q;
    logic    row_end;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            x_q  <= '0;
            y_q  <= '0;
            x0_q <= '0;
            xl_q <= '0;
            yl_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (load_i) begin
                x0_q <= x0_i;
                xl_q <= x_last_i;
                yl_q <= y_last_i;
            end
        end
    end

    // NOTE: every output of this block is assigned before any branch, so no latch
    // can be inferred when a path leaves a signal untouched.
    always_comb begin
        row_end  = (x_q == xl_q);
        last_o   = row_end && (y_q == yl_q);
        next_x_o = row_end ? x0_q : x_q + xcoord_t'(1);
        next_y_o = row_end ? y_q + ycoord_t'(1) : y_q;
        x_d      = x_q;
        y_d      = y_q;
        if (load_i) begin
            x_d = x0_i;
            y_d = y0_i;
        end else if (en_i) begin
            x_d = next_x_o;
            y_d = next_y_o;
        end
    end

`ifdef OUTLINE_EN
    ycoord_t y0_q;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            y0_q <= '0;
        end else if (load_i) begin
            y0_q <= y0_i;
        end
    end

    assign next_edge_o = (next_x_o == x0_q) || (next_x_o == xl_q) ||
                         (next_y_o == y0_q) || (next_y_o == yl_q);
`endif

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle rasteriser: one draw command in, one clipped pixel write per clock out,
// then a one-cycle oDone. Define OUTLINE_EN to add border-only drawing via iOutline.
module rect_fill_engine
    import vga_draw_pkg::*;
#(
    parameter int unsigned XRES = XRES_DEFAULT,
    parameter int unsigned YRES = YRES_DEFAULT
) (
    input logic               iClock,
    input logic               iReset,
    rect_fill_engine_if.slave bus
);

    localparam logic [XW:0] XRES_W = XRES[XW:0];
    localparam logic [YW:0] YRES_W = YRES[YW:0];

    draw_state_e state_q, state_d;
    xcoord_t     x_q, x_d;
    ycoord_t     y_q, y_d;
    colour_t     colour_q, colour_d;
    logic        plot_q, plot_d;

    logic [XW:0] x_room;
    logic [YW:0] y_room;
    xcoord_t     w_clip, x_last, next_x;
    ycoord_t     h_clip, y_last, next_y;
    logic        empty, cnt_load, cnt_en, last_pix;

    // Clip one bit wider than the coordinates so XRES-iX0 cannot wrap.
    always_comb begin
        x_room = XRES_W - {1'b0, bus.iX0};
        y_room = YRES_W - {1'b0, bus.iY0};
        w_clip = '0;
        h_clip = '0;
        if ({1'b0, bus.iX0} < XRES_W) begin
            w_clip = ({1'b0, bus.iW} < x_room) ? bus.iW : x_room[XW-1:0];
        end
        if ({1'b0, bus.iY0} < YRES_W) begin
            h_clip = ({1'b0, bus.iH} < y_room) ? bus.iH : y_room[YW-1:0];
        end
        empty = (w_clip == '0) || (h_clip == '0);
    end

    assign x_last = bus.iX0 + w_clip - xcoord_t'(1);
    assign y_last = bus.iY0 + h_clip - ycoord_t'(1);

`ifdef OUTLINE_EN
    logic outline_q, outline_d, next_edge;
`endif

    raster_counter u_raster (
        .iClock     (iClock),
        .iReset     (iReset),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .x0_i       (bus.iX0),
        .y0_i       (bus.iY0),
        .x_last_i   (x_last),
        .y_last_i   (y_last),
`ifdef OUTLINE_EN
        .next_edge_o(next_edge),
`endif
        .last_o     (last_pix),
        .next_x_o   (next_x),
        .next_y_o   (next_y)
    );

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
`ifdef OUTLINE_EN
            outline_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
`ifdef OUTLINE_EN
            outline_q <= outline_d;
`endif
        end
    end

    // Output registers only move on plotted pixels, so they hold during skipped cycles.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
`ifdef OUTLINE_EN
        outline_d = outline_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    if (empty) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d  = ST_DRAW;
                        cnt_load = 1'b1;
                        x_d      = bus.iX0;
                        y_d      = bus.iY0;
                        colour_d = bus.iColour;
                        plot_d   = 1'b1;
`ifdef OUTLINE_EN
                        outline_d = bus.iOutline;
`endif
                    end
                end
            end
            ST_DRAW: begin
                if (last_pix) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_en = 1'b1;
`ifdef OUTLINE_EN
                    plot_d = !outline_q || next_edge;
`else
                    plot_d = 1'b1;
`endif
                    if (plot_d) begin
                        x_d = next_x;
                        y_d = next_y;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign bus.oX      = x_q;
    assign bus.oY      = y_q;
    assign bus.oColour = colour_q;
    assign bus.oPlot   = plot_q;
    assign bus.oBusy   = (state_q != ST_IDLE);
    assign bus.oDone   = (state_q == ST_FINISH);

endmodule
